memoria_dados_resp: RTL

Data-memory responder for the RISC-V datapath: the memory end of the load/store interface that the datapath drives for `lh`/`sh` (plus byte and word accesses). It accepts one request at a time over a valid/ready handshake, waits a programmable number of cycles, and returns read data or an error over a second valid/ready handshake. Storage is a byte array, little-endian and byte-addressed, so benches can inspect `memoria[i]` directly.

---
 rtl/memoria_dados_resp.sv | 135 +++++++++++++
 1 files changed

// File: rtl/memoria_dados_resp.sv
// Byte-addressed little-endian data memory. It takes one load or store at a time
// and answers a fixed number of cycles after it accepts the request.
module memoria_dados_resp #(
  parameter int PROFUNDIDADE_BYTES = 128,
  parameter int LATENCIA           = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valido,
  output logic        req_pronto,
  input  logic        req_escrita,
  input  logic [1:0]  req_tamanho,
  input  logic        req_sem_sinal,
  input  logic [31:0] req_endereco,
  input  logic [31:0] req_dados,
  output logic        resp_valido,
  input  logic        resp_pronto,
  output logic [31:0] resp_dados,
  output logic        resp_erro
);

  // state    | meaning
  // OCIOSO   | idle, req_pronto high, waiting for a request
  // ESPERA   | request latched, counting down the latency
  // RESPOSTA | response held on resp_* until resp_pronto
  localparam int AW = $clog2(PROFUNDIDADE_BYTES);

  typedef enum logic [1:0] {OCIOSO = 2'd0, ESPERA = 2'd1, RESPOSTA = 2'd2} estado_t;

  estado_t     estado_q;
  logic [3:0]  cont_q;
  logic        escrita_q;
  logic        sem_sinal_q;
  logic [1:0]  tamanho_q;
  logic [31:0] endereco_q;
  logic [31:0] dados_q;
  logic [31:0] resp_dados_q;
  logic        resp_erro_q;

  logic [PROFUNDIDADE_BYTES-1:0][7:0] memoria;

  logic [2:0]    nbytes;
  logic [32:0]   ultimo_d;
  logic          erro_d;
  logic [AW-1:0] idx;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   carga_d;

  always_comb begin
    idx = endereco_q[AW-1:0];
    case (tamanho_q)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: nbytes = 3'd1;
    endcase
    // Range check is done on the full 33-bit sum so high address bits never alias.
    ultimo_d = {1'b0, endereco_q} + {30'd0, nbytes} - 33'd1;
    erro_d = (tamanho_q == 2'b11)
          || ((tamanho_q == 2'b01) && endereco_q[0])
          || ((tamanho_q == 2'b10) && (endereco_q[1:0] != 2'b00))
          || (ultimo_d >= 33'(PROFUNDIDADE_BYTES));
    b0 = memoria[idx];
    b1 = memoria[idx + AW'(1)];
    b2 = memoria[idx + AW'(2)];
    b3 = memoria[idx + AW'(3)];
    case (tamanho_q)
      2'b00:   carga_d = sem_sinal_q ? {24'd0, b0} : {{24{b0[7]}}, b0};
      2'b01:   carga_d = sem_sinal_q ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
      2'b10:   carga_d = {b3, b2, b1, b0};
      default: carga_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q     <= OCIOSO;
      cont_q       <= 4'd0;
      escrita_q    <= 1'b0;
      sem_sinal_q  <= 1'b0;
      tamanho_q    <= 2'b00;
      endereco_q   <= 32'd0;
      dados_q      <= 32'd0;
      resp_dados_q <= 32'd0;
      resp_erro_q  <= 1'b0;
      memoria      <= '0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (req_valido) begin
            escrita_q   <= req_escrita;
            sem_sinal_q <= req_sem_sinal;
            tamanho_q   <= req_tamanho;
            endereco_q  <= req_endereco;
            dados_q     <= req_dados;
            cont_q      <= 4'(LATENCIA - 1);
            estado_q    <= ESPERA;
          end
        end
        ESPERA: begin
          if (cont_q == 4'd0) begin
            estado_q    <= RESPOSTA;
            resp_erro_q <= erro_d;
            if (erro_d || escrita_q) begin
              resp_dados_q <= 32'd0;
            end else begin
              resp_dados_q <= carga_d;
            end
            if (!erro_d && escrita_q) begin
              for (int i = 0; i < 4; i++) begin
                if (i < int'(nbytes)) begin
                  memoria[idx + AW'(i)] <= dados_q[8*i +: 8];
                end
              end
            end
          end else begin
            cont_q <= cont_q - 4'd1;
          end
        end
        RESPOSTA: begin
          if (resp_pronto) begin
            estado_q <= OCIOSO;
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign req_pronto  = (estado_q == OCIOSO);
  assign resp_valido = (estado_q == RESPOSTA);
  assign resp_dados  = resp_dados_q;
  assign resp_erro   = resp_erro_q;

endmodule
